// File: rtl/mask_match_sequencer_if.sv
// Mask-pair input stream and per-beat match output stream of the mask match sequencer.
// The slave modport is the sequencer itself; the master modport is the side that
// supplies mask pairs and consumes match beats.
interface mask_match_sequencer_if #(
    parameter int BITMASK_LENGTH = 16,
    parameter int INDEX_BITWIDTH = 5,
    parameter int LANES          = 2
);
    // mask pair input stream
    logic                              in_valid;
    logic                              in_ready;
    logic [BITMASK_LENGTH-1:0]         in_bitmask_w;
    logic [BITMASK_LENGTH-1:0]         in_bitmask_a;

    // match beat output stream
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES-1:0]                  out_lane_valid;
    logic [LANES*INDEX_BITWIDTH-1:0]   out_position;
    logic [LANES*INDEX_BITWIDTH-1:0]   out_index_w;
    logic [LANES*INDEX_BITWIDTH-1:0]   out_index_a;
    logic                              out_last;
    logic [INDEX_BITWIDTH-1:0]         out_match_count;

    modport slave (
        input  in_valid, in_bitmask_w, in_bitmask_a, out_ready,
        output in_ready, out_valid, out_lane_valid, out_position,
               out_index_w, out_index_a, out_last, out_match_count
    );

    modport master (
        output in_valid, in_bitmask_w, in_bitmask_a, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_position,
               out_index_w, out_index_a, out_last, out_match_count
    );
endinterface

// File: rtl/mask_match_sequencer.sv
// Mask match sequencer: accepts one (W, A) bitmask pair, then walks the matched
// positions (W & A) lowest first, emitting up to LANES matches per beat. Each match
// carries its bit position and the compressed-stream indices popcount(W[pos-1:0]) and
// popcount(A[pos-1:0]). All beat contents are registered; the beat following the
// current one is precomputed from the bits still pending.
module mask_match_sequencer #(
    parameter int BITMASK_LENGTH = 16,
    parameter int INDEX_BITWIDTH = 5,
    parameter int LANES          = 2
) (
    input  logic                        clock,
    input  logic                        resetn,
    mask_match_sequencer_if.slave       bus
);
    localparam int L  = BITMASK_LENGTH;
    localparam int IW = INDEX_BITWIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                 state_q;
    logic [L-1:0]           w_q;
    logic [L-1:0]           a_q;
    // matched bits not yet placed in any beat (excludes the beat on the outputs)
    logic [L-1:0]           rem_q;
    logic [LANES-1:0]       lane_valid_q;
    logic [LANES*IW-1:0]    pos_q;
    logic [LANES*IW-1:0]    idx_w_q;
    logic [LANES*IW-1:0]    idx_a_q;
    logic                   last_q;
    logic [IW-1:0]          count_q;

    // source of the next beat: the incoming pair when idle, the pending bits when scanning
    logic [L-1:0]           src_w;
    logic [L-1:0]           src_a;
    logic [L-1:0]           src_r;

    logic [LANES-1:0]       ext_valid;
    logic [LANES*IW-1:0]    ext_pos;
    logic [LANES*IW-1:0]    ext_iw;
    logic [LANES*IW-1:0]    ext_ia;
    logic [L-1:0]           ext_rest;
    logic                   ext_last;
    logic [IW-1:0]          ext_count;

    // Select which masks feed the beat extractor.
    always_comb begin
        if (state_q == IDLE) begin
            src_w = bus.in_bitmask_w;
            src_a = bus.in_bitmask_a;
            src_r = bus.in_bitmask_w & bus.in_bitmask_a;
        end else begin
            src_w = w_q;
            src_a = a_q;
            src_r = rem_q;
        end
    end

    // Extract the LANES lowest set bits of src_r with their running W/A prefix counts.
    always_comb begin
        int lane;
        logic [IW-1:0] cnt_w;
        logic [IW-1:0] cnt_a;
        ext_valid = '0;
        ext_pos   = '0;
        ext_iw    = '0;
        ext_ia    = '0;
        ext_rest  = src_r;
        ext_count = '0;
        lane      = 0;
        cnt_w     = '0;
        cnt_a     = '0;
        for (int i = 0; i < L; i++) begin
            if (src_r[i] && (lane < LANES)) begin
                ext_valid[lane]          = 1'b1;
                ext_pos[lane*IW +: IW]   = IW'(i);
                ext_iw[lane*IW +: IW]    = cnt_w;
                ext_ia[lane*IW +: IW]    = cnt_a;
                ext_rest[i]              = 1'b0;
                lane                     = lane + 1;
            end
            cnt_w     = cnt_w + IW'(src_w[i]);
            cnt_a     = cnt_a + IW'(src_a[i]);
            ext_count = ext_count + IW'(src_r[i]);
        end
        ext_last = (ext_rest == '0);
    end

    // Sequencer FSM: capture a pair in IDLE, advance one beat per accepted transfer in SCAN.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            w_q          <= '0;
            a_q          <= '0;
            rem_q        <= '0;
            lane_valid_q <= '0;
            pos_q        <= '0;
            idx_w_q      <= '0;
            idx_a_q      <= '0;
            last_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_q          <= bus.in_bitmask_w;
                        a_q          <= bus.in_bitmask_a;
                        rem_q        <= ext_rest;
                        lane_valid_q <= ext_valid;
                        pos_q        <= ext_pos;
                        idx_w_q      <= ext_iw;
                        idx_a_q      <= ext_ia;
                        last_q       <= ext_last;
                        count_q      <= ext_count;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            // pair finished: return outputs to their quiet values
                            state_q      <= IDLE;
                            w_q          <= '0;
                            a_q          <= '0;
                            rem_q        <= '0;
                            lane_valid_q <= '0;
                            pos_q        <= '0;
                            idx_w_q      <= '0;
                            idx_a_q      <= '0;
                            last_q       <= 1'b0;
                            count_q      <= '0;
                        end else begin
                            rem_q        <= ext_rest;
                            lane_valid_q <= ext_valid;
                            pos_q        <= ext_pos;
                            idx_w_q      <= ext_iw;
                            idx_a_q      <= ext_ia;
                            last_q       <= ext_last;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready        = (state_q == IDLE);
    assign bus.out_valid       = (state_q == SCAN);
    assign bus.out_lane_valid  = lane_valid_q;
    assign bus.out_position    = pos_q;
    assign bus.out_index_w     = idx_w_q;
    assign bus.out_index_a     = idx_a_q;
    assign bus.out_last        = last_q;
    assign bus.out_match_count = count_q;
endmodule

// File: tb/tb_mask_match_sequencer.sv
// Bench for mask_match_sequencer: three builds (LANES = 2, 1, 16) with L=16, IW=5.
// Directed scenarios run on the LANES=2 build; randomized pairs run on all builds
// against a list-based reference model of the matched positions.
module tb_mask_match_sequencer;
    localparam int L  = 16;
    localparam int IW = 5;
    localparam int NI = 3;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic        in_valid_u  [NI];
    logic        out_ready_u [NI];
    logic [15:0] bw;
    logic [15:0] ba;

    logic        in_ready_u  [NI];
    logic        out_valid_u [NI];
    logic        last_u      [NI];
    logic [15:0] lane_f      [NI];
    logic [79:0] pos_f       [NI];
    logic [79:0] iw_f        [NI];
    logic [79:0] ia_f        [NI];
    logic [4:0]  cnt_u       [NI];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lanes_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 16);
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LN = (gi == 0) ? 2 : ((gi == 1) ? 1 : 16);
        mask_match_sequencer_if #(.BITMASK_LENGTH(L), .INDEX_BITWIDTH(IW), .LANES(LN)) bus ();
        mask_match_sequencer #(.BITMASK_LENGTH(L), .INDEX_BITWIDTH(IW), .LANES(LN)) u_dut (
            .clock  (clock),
            .resetn (resetn),
            .bus    (bus.slave)
        );
        assign bus.in_valid     = in_valid_u[gi];
        assign bus.out_ready    = out_ready_u[gi];
        assign bus.in_bitmask_w = bw;
        assign bus.in_bitmask_a = ba;
        assign in_ready_u[gi]   = bus.in_ready;
        assign out_valid_u[gi]  = bus.out_valid;
        assign last_u[gi]       = bus.out_last;
        assign lane_f[gi]       = 16'(bus.out_lane_valid);
        assign pos_f[gi]        = 80'(bus.out_position);
        assign iw_f[gi]         = 80'(bus.out_index_w);
        assign ia_f[gi]         = 80'(bus.out_index_a);
        assign cnt_u[gi]        = bus.out_match_count;
    end

    // Reference: list the matched positions, then slice beat b out of that list.
    function automatic void model_beat(input logic [15:0] w, input logic [15:0] a,
                                       input int ln, input int b,
                                       output logic [15:0] lv, output logic [79:0] pos,
                                       output logic [79:0] iw, output logic [79:0] ia,
                                       output logic last);
        int q[$];
        logic [15:0] below;
        lv = '0; pos = '0; iw = '0; ia = '0;
        for (int p = 0; p < 16; p++) if (w[p] && a[p]) q.push_back(p);
        for (int j = 0; j < ln; j++) begin
            if (b * ln + j < q.size()) begin
                int p;
                p = q[b * ln + j];
                below = 16'((32'd1 << p) - 32'd1);
                lv[j] = 1'b1;
                pos[j*5 +: 5] = 5'(p);
                iw[j*5 +: 5]  = 5'($countones(w & below));
                ia[j*5 +: 5]  = 5'($countones(a & below));
            end
        end
        last = ((b + 1) * ln >= q.size());
    endfunction

    // Present a pair for one cycle (caller is at a falling edge with the build idle),
    // then scramble the mask inputs so the registered copy is the only source.
    task automatic drive_pair(input int k, input logic [15:0] w, input logic [15:0] a);
        bw = w; ba = a; in_valid_u[k] = 1'b1;
        @(negedge clock);
        in_valid_u[k] = 1'b0;
        bw = 16'($urandom); ba = 16'($urandom);
    endtask

    task automatic test_reset;
        for (int k = 0; k < NI; k++) begin
            n_cmp++; if ({out_valid_u[k], last_u[k], in_ready_u[k]} !== 3'b001) begin n_bad++; $display("FAIL rst_ctrl[%0d]: got %b expected 001", k, {out_valid_u[k], last_u[k], in_ready_u[k]}); end
            n_cmp++; if ({lane_f[k], pos_f[k], iw_f[k], ia_f[k], cnt_u[k]} !== '0) begin n_bad++; $display("FAIL rst_data[%0d]: got lane %h pos %h cnt %h expected zeros", k, lane_f[k], pos_f[k], cnt_u[k]); end
        end
        resetn = 1'b1;
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            n_cmp++; if ({out_valid_u[k], in_ready_u[k]} !== 2'b01) begin n_bad++; $display("FAIL rst_release[%0d]: got %b expected 01", k, {out_valid_u[k], in_ready_u[k]}); end
        end
        $display("reset: all builds idle");
    endtask

    task automatic test_sparse_two_beats;
        out_ready_u[0] = 1'b1;
        drive_pair(0, 16'hF0F0, 16'hFF00);
        n_cmp++; if ({out_valid_u[0], in_ready_u[0], last_u[0]} !== 3'b100) begin n_bad++; $display("FAIL s1_b1_ctrl: got %b expected 100", {out_valid_u[0], in_ready_u[0], last_u[0]}); end
        n_cmp++; if (lane_f[0] !== 16'h0003) begin n_bad++; $display("FAIL s1_b1_lane: got %h expected 0003", lane_f[0]); end
        n_cmp++; if (pos_f[0] !== 80'({5'd13, 5'd12})) begin n_bad++; $display("FAIL s1_b1_pos: got %h expected %h", pos_f[0], 80'({5'd13, 5'd12})); end
        n_cmp++; if (iw_f[0] !== 80'({5'd5, 5'd4})) begin n_bad++; $display("FAIL s1_b1_iw: got %h expected %h", iw_f[0], 80'({5'd5, 5'd4})); end
        n_cmp++; if (ia_f[0] !== 80'({5'd5, 5'd4})) begin n_bad++; $display("FAIL s1_b1_ia: got %h expected %h", ia_f[0], 80'({5'd5, 5'd4})); end
        n_cmp++; if (cnt_u[0] !== 5'd4) begin n_bad++; $display("FAIL s1_count: got %0d expected 4", cnt_u[0]); end
        @(negedge clock);
        n_cmp++; if ({out_valid_u[0], last_u[0]} !== 2'b11) begin n_bad++; $display("FAIL s1_b2_ctrl: got %b expected 11", {out_valid_u[0], last_u[0]}); end
        n_cmp++; if (pos_f[0] !== 80'({5'd15, 5'd14})) begin n_bad++; $display("FAIL s1_b2_pos: got %h expected %h", pos_f[0], 80'({5'd15, 5'd14})); end
        n_cmp++; if (iw_f[0] !== 80'({5'd7, 5'd6}) || ia_f[0] !== 80'({5'd7, 5'd6})) begin n_bad++; $display("FAIL s1_b2_idx: got w %h a %h expected %h", iw_f[0], ia_f[0], 80'({5'd7, 5'd6})); end
        n_cmp++; if (cnt_u[0] !== 5'd4) begin n_bad++; $display("FAIL s1_b2_count: got %0d expected 4", cnt_u[0]); end
        @(negedge clock);
        n_cmp++; if ({out_valid_u[0], in_ready_u[0]} !== 2'b01) begin n_bad++; $display("FAIL s1_idle: got %b expected 01", {out_valid_u[0], in_ready_u[0]}); end
        $display("pair W=F0F0 A=FF00: 2 beats");
    endtask

    task automatic test_zero_match;
        out_ready_u[0] = 1'b1;
        drive_pair(0, 16'h00FF, 16'hFF00);
        n_cmp++; if ({out_valid_u[0], last_u[0], lane_f[0]} !== {2'b11, 16'h0000}) begin n_bad++; $display("FAIL s2_beat: got valid/last %b lane %h expected 11 / 0000", {out_valid_u[0], last_u[0]}, lane_f[0]); end
        n_cmp++; if (cnt_u[0] !== 5'd0) begin n_bad++; $display("FAIL s2_count: got %0d expected 0", cnt_u[0]); end
        @(negedge clock);
        n_cmp++; if ({out_valid_u[0], in_ready_u[0]} !== 2'b01) begin n_bad++; $display("FAIL s2_idle: got %b expected 01", {out_valid_u[0], in_ready_u[0]}); end
        $display("pair W=00FF A=FF00: zero match, 1 beat");
    endtask

    task automatic test_low_positions;
        out_ready_u[0] = 1'b1;
        drive_pair(0, 16'h0007, 16'h0005);
        n_cmp++; if ({out_valid_u[0], last_u[0], lane_f[0]} !== {2'b11, 16'h0003}) begin n_bad++; $display("FAIL s3a_ctrl: got valid/last %b lane %h expected 11 / 0003", {out_valid_u[0], last_u[0]}, lane_f[0]); end
        n_cmp++; if (pos_f[0] !== 80'({5'd2, 5'd0})) begin n_bad++; $display("FAIL s3a_pos: got %h expected %h", pos_f[0], 80'({5'd2, 5'd0})); end
        n_cmp++; if (iw_f[0] !== 80'({5'd2, 5'd0})) begin n_bad++; $display("FAIL s3a_iw: got %h expected %h", iw_f[0], 80'({5'd2, 5'd0})); end
        n_cmp++; if (ia_f[0] !== 80'({5'd1, 5'd0})) begin n_bad++; $display("FAIL s3a_ia: got %h expected %h", ia_f[0], 80'({5'd1, 5'd0})); end
        @(negedge clock);
        drive_pair(0, 16'h0007, 16'h0007);
        n_cmp++; if ({last_u[0], lane_f[0], pos_f[0]} !== {1'b0, 16'h0003, 80'({5'd1, 5'd0})}) begin n_bad++; $display("FAIL s3b_b1: got last %b lane %h pos %h expected 0 0003 %h", last_u[0], lane_f[0], pos_f[0], 80'({5'd1, 5'd0})); end
        @(negedge clock);
        n_cmp++; if ({last_u[0], lane_f[0], pos_f[0]} !== {1'b1, 16'h0001, 80'(5'd2)}) begin n_bad++; $display("FAIL s3b_b2: got last %b lane %h pos %h expected 1 0001 %h", last_u[0], lane_f[0], pos_f[0], 80'(5'd2)); end
        n_cmp++; if ({iw_f[0], ia_f[0], cnt_u[0]} !== {80'(5'd2), 80'(5'd2), 5'd3}) begin n_bad++; $display("FAIL s3b_idx: got w %h a %h cnt %0d expected 2 2 3", iw_f[0], ia_f[0], cnt_u[0]); end
        @(negedge clock);
        $display("pairs W=0007 A=0005 and W=A=0007");
    endtask

    task automatic test_full_mask_stall;
        logic [79:0] e;
        int b;
        int cyc;
        bit rdy;
        out_ready_u[0] = 1'b0;
        drive_pair(0, 16'hFFFF, 16'hFFFF);
        for (int s = 0; s < 5; s++) begin
            n_cmp++; if ({out_valid_u[0], in_ready_u[0], lane_f[0], pos_f[0]} !== {2'b10, 16'h0003, 80'({5'd1, 5'd0})}) begin n_bad++; $display("FAIL s4_stall%0d: got v/r %b lane %h pos %h expected held beat 0", s, {out_valid_u[0], in_ready_u[0]}, lane_f[0], pos_f[0]); end
            @(negedge clock);
        end
        b = 0; cyc = 0;
        while (b < 8 && cyc < 100) begin
            e = 80'({5'(2 * b + 1), 5'(2 * b)});
            n_cmp++; if ({out_valid_u[0], in_ready_u[0], last_u[0]} !== {2'b10, (b == 7)}) begin n_bad++; $display("FAIL s4_ctrl_b%0d: got %b expected %b", b, {out_valid_u[0], in_ready_u[0], last_u[0]}, {2'b10, (b == 7)}); end
            n_cmp++; if ({lane_f[0], pos_f[0], iw_f[0], ia_f[0]} !== {16'h0003, e, e, e}) begin n_bad++; $display("FAIL s4_data_b%0d: got lane %h pos %h iw %h ia %h expected pos=idx=%h", b, lane_f[0], pos_f[0], iw_f[0], ia_f[0], e); end
            n_cmp++; if (cnt_u[0] !== 5'd16) begin n_bad++; $display("FAIL s4_count_b%0d: got %0d expected 16", b, cnt_u[0]); end
            rdy = 1'($urandom_range(0, 1));
            out_ready_u[0] = rdy;
            if (rdy) b++;
            @(negedge clock);
            cyc++;
        end
        n_cmp++; if (cyc >= 100) begin n_bad++; $display("FAIL s4_timeout: got %0d beats expected 8", b); end
        n_cmp++; if ({out_valid_u[0], in_ready_u[0]} !== 2'b01) begin n_bad++; $display("FAIL s4_idle: got %b expected 01", {out_valid_u[0], in_ready_u[0]}); end
        out_ready_u[0] = 1'b1;
        $display("pair W=A=FFFF with stalls: 8 beats in %0d cycles", cyc + 5);
    endtask

    task automatic test_reset_mid_scan;
        out_ready_u[0] = 1'b1;
        drive_pair(0, 16'hF0F0, 16'hFF00);
        @(negedge clock);
        n_cmp++; if (pos_f[0] !== 80'({5'd15, 5'd14})) begin n_bad++; $display("FAIL s5_pre: got %h expected %h", pos_f[0], 80'({5'd15, 5'd14})); end
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if ({out_valid_u[0], last_u[0], in_ready_u[0]} !== 3'b001) begin n_bad++; $display("FAIL s5_async: got %b expected 001", {out_valid_u[0], last_u[0], in_ready_u[0]}); end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        n_cmp++; if ({out_valid_u[0], in_ready_u[0]} !== 2'b01) begin n_bad++; $display("FAIL s5_release: got %b expected 01", {out_valid_u[0], in_ready_u[0]}); end
        drive_pair(0, 16'h0007, 16'h0005);
        n_cmp++; if ({last_u[0], pos_f[0], iw_f[0], ia_f[0]} !== {1'b1, 80'({5'd2, 5'd0}), 80'({5'd2, 5'd0}), 80'({5'd1, 5'd0})}) begin n_bad++; $display("FAIL s5_next: got last %b pos %h iw %h ia %h", last_u[0], pos_f[0], iw_f[0], ia_f[0]); end
        @(negedge clock);
        $display("reset during beat 2, then pair W=0007 A=0005");
    endtask

    task automatic test_random_lanes(input int k, input int npairs);
        logic [15:0] w;
        logic [15:0] a;
        logic [15:0] e_lv;
        logic [79:0] e_pos;
        logic [79:0] e_iw;
        logic [79:0] e_ia;
        logic        e_last;
        logic [4:0]  e_cnt;
        int b;
        int cyc;
        bit rdy;
        bit done;
        int ln;
        ln = lanes_of(k);
        for (int p = 0; p < npairs; p++) begin
            case ($urandom_range(0, 3))
                0: begin w = 16'($urandom); a = 16'($urandom); end
                1: begin w = 16'($urandom & $urandom); a = 16'($urandom | $urandom); end
                2: begin w = 16'hFFFF; a = 16'($urandom); end
                default: begin w = 16'($urandom); a = w; end
            endcase
            e_cnt = 5'($countones(w & a));
            n_cmp++; if (in_ready_u[k] !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready: got %b expected 1 before pair %0d", ln, in_ready_u[k], p); end
            drive_pair(k, w, a);
            b = 0; cyc = 0; done = 1'b0;
            while (!done) begin
                model_beat(w, a, ln, b, e_lv, e_pos, e_iw, e_ia, e_last);
                n_cmp++; if ({out_valid_u[k], in_ready_u[k], last_u[k]} !== {2'b10, e_last}) begin n_bad++; $display("FAIL rnd%0d_ctrl: pair %h/%h beat %0d got %b expected %b", ln, w, a, b, {out_valid_u[k], in_ready_u[k], last_u[k]}, {2'b10, e_last}); end
                n_cmp++; if (lane_f[k] !== e_lv) begin n_bad++; $display("FAIL rnd%0d_lane: pair %h/%h beat %0d got %h expected %h", ln, w, a, b, lane_f[k], e_lv); end
                n_cmp++; if (pos_f[k] !== e_pos) begin n_bad++; $display("FAIL rnd%0d_pos: pair %h/%h beat %0d got %h expected %h", ln, w, a, b, pos_f[k], e_pos); end
                n_cmp++; if (iw_f[k] !== e_iw) begin n_bad++; $display("FAIL rnd%0d_iw: pair %h/%h beat %0d got %h expected %h", ln, w, a, b, iw_f[k], e_iw); end
                n_cmp++; if (ia_f[k] !== e_ia) begin n_bad++; $display("FAIL rnd%0d_ia: pair %h/%h beat %0d got %h expected %h", ln, w, a, b, ia_f[k], e_ia); end
                n_cmp++; if (cnt_u[k] !== e_cnt) begin n_bad++; $display("FAIL rnd%0d_count: pair %h/%h got %0d expected %0d", ln, w, a, cnt_u[k], e_cnt); end
                rdy = ($urandom_range(0, 3) != 0);
                out_ready_u[k] = rdy;
                // stray in_valid while scanning must be ignored; drop it before the idle cycle
                in_valid_u[k] = (rdy && e_last) ? 1'b0 : 1'($urandom_range(0, 1));
                bw = 16'($urandom); ba = 16'($urandom);
                if (rdy) begin
                    b++;
                    if (e_last) done = 1'b1;
                end
                @(negedge clock);
                cyc++;
                if (!done && cyc > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rnd%0d_timeout: pair %h/%h stuck at beat %0d", ln, w, a, b);
                    done = 1'b1;
                end
            end
            in_valid_u[k] = 1'b0;
            n_cmp++; if ({out_valid_u[k], in_ready_u[k]} !== 2'b01) begin n_bad++; $display("FAIL rnd%0d_idle: pair %h/%h got %b expected 01", ln, w, a, {out_valid_u[k], in_ready_u[k]}); end
            $display("lanes=%0d pair %0d W=%h A=%h beats=%0d cycles=%0d", ln, p, w, a, b, cyc + 1);
        end
        out_ready_u[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            in_valid_u[k]  = 1'b0;
            out_ready_u[k] = 1'b1;
        end
        bw = '0; ba = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        test_reset;
        test_sparse_two_beats;
        test_zero_match;
        test_low_positions;
        test_full_mask_stall;
        test_reset_mid_scan;
        test_random_lanes(0, 500);
        test_random_lanes(1, 1000);
        test_random_lanes(2, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog");
    end
endmodule
